segment_capture: RTL and testbench

Receive side of the multiplexed 7-segment display bus. Observes the active-low digit enables and the segment code bus, decodes each 7-segment code back to a BCD digit, and assembles four digits into two 6-bit binary fields (hours/minutes style). Used as an on-chip display loopback monitor and as a front end for any block that has to read a scanned display. Output is published only after a stable, error-free frame.

---
 rtl/seg7_pkg.sv | 30 +++
 rtl/seg7_decode.sv | 35 +++
 rtl/segment_capture.sv | 158 +++++++++++++++
 tb/tb_segment_capture.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared constants for 7-segment display bus consumers: segment codes,
// digit slot indices and the binary field width.
package seg7_pkg;

  localparam logic [6:0] SEG_0     = 7'h3f;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5b;
  localparam logic [6:0] SEG_3     = 7'h4f;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6d;
  localparam logic [6:0] SEG_6     = 7'h7d;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7f;
  localparam logic [6:0] SEG_9     = 7'h6f;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  localparam int LO_ONES    = 0;
  localparam int LO_TENS    = 1;
  localparam int HI_ONES    = 2;
  localparam int HI_TENS    = 3;
  localparam int NUM_DIGITS = 4;

  localparam int FIELD_W = 6;

  // Kept at 7 bits so a 99 from two BCD digits is still visible for range checks.
  function automatic logic [6:0] field_value(input logic [3:0] tens, input logic [3:0] ones);
    return 7'(tens) * 7'd10 + 7'(ones);
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational 7-segment code to BCD decoder; flags blank and
// unrecognised codes separately so callers can ignore blanks.
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [6:0] code,
  output logic [3:0] digit,
  output logic       valid,
  output logic       blank
);

  always_comb begin
    digit = 4'd0;
    valid = 1'b1;
    blank = 1'b0;
    case (code)
      SEG_0:     digit = 4'd0;
      SEG_1:     digit = 4'd1;
      SEG_2:     digit = 4'd2;
      SEG_3:     digit = 4'd3;
      SEG_4:     digit = 4'd4;
      SEG_5:     digit = 4'd5;
      SEG_6:     digit = 4'd6;
      SEG_7:     digit = 4'd7;
      SEG_8:     digit = 4'd8;
      SEG_9:     digit = 4'd9;
      SEG_BLANK: begin
        valid = 1'b0;
        blank = 1'b1;
      end
      default:   valid = 1'b0;
    endcase
  end

endmodule

// File: rtl/segment_capture.sv
// Scanned 7-segment display receiver: realigns the segment bus to its digit
// enable, collects four digits and publishes two binary fields once stable.
module segment_capture
  import seg7_pkg::*;
#(
  parameter int SEG_LAG       = 1,
  parameter int STABLE_FRAMES = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [3:0]  bytee,
  input  logic [6:0]  segment,
  output logic [11:0] data_out,
  output logic        data_valid,
  output logic        code_error,
  output logic        enable_error,
  output logic [15:0] digit_bcd
);

  localparam logic [3:0] STABLE_CNT = 4'(STABLE_FRAMES);
  localparam logic [6:0] FIELD_MAX  = 7'((1 << FIELD_W) - 1);

  logic [3:0] en_d;

  generate
    if (SEG_LAG == 0) begin : g_nolag
      assign en_d = bytee;
    end else begin : g_lag
      logic [3:0] lag_q [SEG_LAG];
      always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
          for (int i = 0; i < SEG_LAG; i++) lag_q[i] <= 4'hF;
        end else begin
          lag_q[0] <= bytee;
          for (int i = 1; i < SEG_LAG; i++) lag_q[i] <= lag_q[i-1];
        end
      end
      assign en_d = lag_q[SEG_LAG-1];
    end
  endgenerate

  logic [3:0] dec_digit;
  logic       dec_valid;
  logic       dec_blank;

  seg7_decode u_decode (
    .code  (segment),
    .digit (dec_digit),
    .valid (dec_valid),
    .blank (dec_blank)
  );

  logic [3:0] sel;
  logic       one_hot;
  logic       multi;
  logic       code_bad;

  assign sel      = ~en_d;
  assign one_hot  = (sel != 4'd0) && ((sel & (sel - 4'd1)) == 4'd0);
  assign multi    = (sel != 4'd0) && !one_hot;
  assign code_bad = !dec_valid && !dec_blank;

  logic [NUM_DIGITS-1:0][3:0] digit_q, digit_d;
  logic [NUM_DIGITS-1:0]      flags_q, flags_d;
  logic [11:0]                candidate_q, candidate_d;
  logic [3:0]                 count_q, count_d;
  logic [11:0]                data_out_q, data_out_d;
  logic                       data_valid_q, data_valid_d;
  logic                       code_error_q, code_error_d;
  logic                       enable_error_q, enable_error_d;

  logic [6:0]  hi_val;
  logic [6:0]  lo_val;
  logic        range_ok;
  logic        frame_done;
  logic [11:0] frame_value;

  assign hi_val      = field_value(digit_q[HI_TENS], digit_q[HI_ONES]);
  assign lo_val      = field_value(digit_q[LO_TENS], digit_q[LO_ONES]);
  assign range_ok    = (hi_val <= FIELD_MAX) && (lo_val <= FIELD_MAX);
  assign frame_done  = &flags_q;
  assign frame_value = {hi_val[FIELD_W-1:0], lo_val[FIELD_W-1:0]};

  always_comb begin
    digit_d        = digit_q;
    flags_d        = flags_q;
    candidate_d    = candidate_q;
    count_d        = count_q;
    data_out_d     = data_out_q;
    data_valid_d   = 1'b0;
    code_error_d   = 1'b0;
    enable_error_d = 1'b0;

    // Stability runs one edge after completion, on the digit registers as they
    // stood; a new sample landing on the same edge starts the next frame.
    if (frame_done) begin
      flags_d = '0;
      if (range_ok) begin
        if (frame_value == candidate_q) begin
          count_d = (count_q == 4'd15) ? count_q : count_q + 4'd1;
        end else begin
          candidate_d = frame_value;
          count_d     = 4'd1;
        end
        if (count_d >= STABLE_CNT) begin
          data_out_d   = frame_value;
          data_valid_d = 1'b1;
        end
      end
    end

    if (multi) begin
      flags_d        = '0;
      enable_error_d = 1'b1;
    end else if (one_hot) begin
      if (code_bad) begin
        flags_d      = '0;
        code_error_d = 1'b1;
      end else if (dec_valid) begin
        for (int i = 0; i < NUM_DIGITS; i++) begin
          if (sel[i]) begin
            digit_d[i] = dec_digit;
            flags_d[i] = 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      digit_q        <= '0;
      flags_q        <= '0;
      candidate_q    <= '0;
      count_q        <= '0;
      data_out_q     <= '0;
      data_valid_q   <= 1'b0;
      code_error_q   <= 1'b0;
      enable_error_q <= 1'b0;
    end else begin
      digit_q        <= digit_d;
      flags_q        <= flags_d;
      candidate_q    <= candidate_d;
      count_q        <= count_d;
      data_out_q     <= data_out_d;
      data_valid_q   <= data_valid_d;
      code_error_q   <= code_error_d;
      enable_error_q <= enable_error_d;
    end
  end

  assign data_out     = data_out_q;
  assign data_valid   = data_valid_q;
  assign code_error   = code_error_q;
  assign enable_error = enable_error_q;
  assign digit_bcd    = digit_q;

endmodule

// File: tb/tb_segment_capture.sv
// Directed bench for segment_capture (SEG_LAG=1, STABLE_FRAMES=2): scans
// frames on the display bus and checks outputs against hand-computed values.
module tb_segment_capture;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  bytee = 4'hF;
  logic [6:0]  segment = 7'h00;
  logic [11:0] data_out;
  logic        data_valid;
  logic        code_error;
  logic        enable_error;
  logic [15:0] digit_bcd;

  int checks  = 0;
  int errors  = 0;
  int n_valid = 0;
  int n_cerr  = 0;
  int n_eerr  = 0;
  logic [6:0] prev_seg = 7'h00;

  always #5 clock = ~clock;

  segment_capture #(
    .SEG_LAG       (1),
    .STABLE_FRAMES (2)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .bytee        (bytee),
    .segment      (segment),
    .data_out     (data_out),
    .data_valid   (data_valid),
    .code_error   (code_error),
    .enable_error (enable_error),
    .digit_bcd    (digit_bcd)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [6:0] enc(input int d);
    case (d)
      0: return 7'h3f;
      1: return 7'h06;
      2: return 7'h5b;
      3: return 7'h4f;
      4: return 7'h66;
      5: return 7'h6d;
      6: return 7'h7d;
      7: return 7'h07;
      8: return 7'h7f;
      9: return 7'h6f;
      default: return 7'h00;
    endcase
  endfunction

  // Segment bus lags the enables by one clock: drive this slot's enable now
  // and the previous slot's code alongside it.
  task automatic cycle(input logic [3:0] en, input logic [6:0] seg);
    bytee    = en;
    segment  = prev_seg;
    prev_seg = seg;
    @(posedge clock);
    #1;
    n_valid += int'(data_valid);
    n_cerr  += int'(code_error);
    n_eerr  += int'(enable_error);
  endtask

  task automatic clr_counts();
    n_valid = 0;
    n_cerr  = 0;
    n_eerr  = 0;
  endtask

  task automatic frame(input int d3, input int d2, input int d1, input int d0);
    cycle(4'b1110, enc(d0));
    cycle(4'b1101, enc(d1));
    cycle(4'b1011, enc(d2));
    cycle(4'b0111, enc(d3));
  endtask

  task automatic flush();
    repeat (3) cycle(4'hF, 7'h00);
  endtask

  task automatic do_reset();
    reset    = 1'b0;
    bytee    = 4'hF;
    segment  = 7'h00;
    prev_seg = 7'h00;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b1;
    clr_counts();
  endtask

  initial begin
    // Reset state
    do_reset();
    check("rst_data_out", 16'(data_out), 16'h000);
    check("rst_digit_bcd", digit_bcd, 16'h0000);
    check("rst_data_valid", 16'(data_valid), 16'h0);
    check("rst_code_error", 16'(code_error), 16'h0);
    check("rst_enable_error", 16'(enable_error), 16'h0);

    // Two clean frames {12,34}: publish only after the second, 2 clocks after last sample
    frame(1, 2, 3, 4);
    flush();
    check("f1_no_valid", 16'(n_valid), 16'd0);
    check("f1_digit_bcd", digit_bcd, 16'h1234);
    clr_counts();
    frame(1, 2, 3, 4);
    cycle(4'hF, 7'h00);
    check("lat_sample_edge", 16'(data_valid), 16'h0);
    cycle(4'hF, 7'h00);
    check("lat_publish_edge", 16'(data_valid), 16'h1);
    flush();
    check("f2_valid_count", 16'(n_valid), 16'd1);
    check("f2_data_out", 16'(data_out), 16'h322);
    check("f2_digit_bcd", digit_bcd, 16'h1234);

    // Invalid code 7b on digit 1 discards the frame
    do_reset();
    frame(1, 2, 3, 4);
    cycle(4'b1110, enc(4));
    cycle(4'b1101, 7'h7b);
    cycle(4'b1011, enc(2));
    cycle(4'b0111, enc(1));
    flush();
    check("cerr_count", 16'(n_cerr), 16'd1);
    check("cerr_no_valid", 16'(n_valid), 16'd0);
    frame(1, 2, 3, 4);
    flush();
    check("cerr_recover_valid", 16'(n_valid), 16'd1);
    check("cerr_recover_data", 16'(data_out), 16'h322);

    // Two enables low mid-frame: flags cleared, publication one frame later
    do_reset();
    frame(1, 2, 3, 4);
    cycle(4'b1110, enc(4));
    cycle(4'b1101, enc(3));
    cycle(4'b1100, enc(1));
    cycle(4'b1011, enc(2));
    cycle(4'b0111, enc(1));
    flush();
    check("eerr_count", 16'(n_eerr), 16'd1);
    check("eerr_no_valid", 16'(n_valid), 16'd0);
    check("eerr_no_cerr", 16'(n_cerr), 16'd0);
    frame(1, 2, 3, 4);
    flush();
    check("eerr_recover_valid", 16'(n_valid), 16'd1);
    check("eerr_recover_data", 16'(data_out), 16'h322);

    // Low field 99 is out of range: silently discarded
    do_reset();
    frame(1, 2, 3, 4);
    frame(1, 2, 3, 4);
    flush();
    check("rng_setup_data", 16'(data_out), 16'h322);
    clr_counts();
    frame(1, 2, 9, 9);
    frame(1, 2, 9, 9);
    flush();
    check("rng_no_valid", 16'(n_valid), 16'd0);
    check("rng_no_cerr", 16'(n_cerr), 16'd0);
    check("rng_no_eerr", 16'(n_eerr), 16'd0);
    check("rng_data_held", 16'(data_out), 16'h322);
    check("rng_digit_bcd", digit_bcd, 16'h1299);

    // Alternating values never stabilise; then two {12,35} frames publish
    clr_counts();
    frame(1, 2, 3, 5);
    frame(1, 2, 3, 4);
    frame(1, 2, 3, 5);
    frame(1, 2, 3, 4);
    flush();
    check("alt_no_valid", 16'(n_valid), 16'd0);
    clr_counts();
    frame(1, 2, 3, 5);
    frame(1, 2, 3, 5);
    flush();
    check("alt_stable_valid", 16'(n_valid), 16'd1);
    check("alt_stable_data", 16'(data_out), 16'h323);

    // Blank slots and code 00 on an enabled digit are ignored
    do_reset();
    repeat (2) begin
      cycle(4'b1110, enc(4));
      cycle(4'hF, 7'h00);
      cycle(4'b1101, 7'h00);
      cycle(4'b1101, enc(3));
      cycle(4'b1011, enc(2));
      cycle(4'hF, 7'h00);
      cycle(4'b0111, enc(1));
    end
    flush();
    check("blank_valid", 16'(n_valid), 16'd1);
    check("blank_data", 16'(data_out), 16'h322);
    check("blank_no_cerr", 16'(n_cerr), 16'd0);
    check("blank_no_eerr", 16'(n_eerr), 16'd0);

    // Asynchronous reset mid-frame clears outputs immediately
    cycle(4'b1110, enc(4));
    cycle(4'b1101, enc(3));
    #2;
    reset = 1'b0;
    #1;
    check("midrst_data_out", 16'(data_out), 16'h000);
    check("midrst_digit_bcd", digit_bcd, 16'h0000);
    check("midrst_data_valid", 16'(data_valid), 16'h0);
    bytee    = 4'hF;
    segment  = 7'h00;
    prev_seg = 7'h00;
    @(posedge clock);
    #1;
    reset = 1'b1;
    clr_counts();
    frame(1, 2, 3, 4);
    flush();
    check("post_rst_f1_no_valid", 16'(n_valid), 16'd0);
    frame(1, 2, 3, 4);
    flush();
    check("post_rst_f2_valid", 16'(n_valid), 16'd1);
    check("post_rst_f2_data", 16'(data_out), 16'h322);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
